// File: rtl/alu_ctrl_decoder.sv
// RV32I decode stage: registered ALU controls behind a 2-entry skid buffer (EMPTY/ONE/TWO).
// Optional macro ALU_DEC_PERF_CNT_EN adds the perf_decoded / perf_illegal transfer counters.
module alu_ctrl_decoder #(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_instr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [3:0]   out_alu_op,
   output logic         out_alusrc,
   output logic [N-1:0] out_imm,
   output logic [4:0]   out_rs1,
   output logic [4:0]   out_rs2,
   output logic [4:0]   out_rd,
   output logic         out_rd_we,
   output logic         out_is_branch,
   output logic         out_br_invert,
   output logic         out_illegal
`ifdef ALU_DEC_PERF_CNT_EN
   ,
   output logic [31:0]  perf_decoded,
   output logic [31:0]  perf_illegal
`endif
);

   localparam int unsigned OPC_W = 7;
   localparam int unsigned OPW   = 4;

   localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [OPW-1:0] ALU_ADD  = 4'b0000;
   localparam logic [OPW-1:0] ALU_SUB  = 4'b0001;
   localparam logic [OPW-1:0] ALU_AND  = 4'b0010;
   localparam logic [OPW-1:0] ALU_OR   = 4'b0011;
   localparam logic [OPW-1:0] ALU_XOR  = 4'b0100;
   localparam logic [OPW-1:0] ALU_EQ   = 4'b0101;
   localparam logic [OPW-1:0] ALU_SLT  = 4'b0110;
   localparam logic [OPW-1:0] ALU_SLTU = 4'b1000;
   localparam logic [OPW-1:0] ALU_SLL  = 4'b1001;
   localparam logic [OPW-1:0] ALU_SRL  = 4'b1010;
   localparam logic [OPW-1:0] ALU_SRA  = 4'b1011;

   typedef struct packed {
      logic [OPW-1:0] alu_op;
      logic           alusrc;
      logic [N-1:0]   imm;
      logic [4:0]     rs1;
      logic [4:0]     rs2;
      logic [4:0]     rd;
      logic           rd_we;
      logic           is_branch;
      logic           br_invert;
      logic           illegal;
   } bundle_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   // Shared funct3 map of the register and immediate ALU groups
   function automatic logic [OPW-1:0] f3_op(input logic [2:0] f3);
      logic [OPW-1:0] op;
      op = ALU_ADD;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   logic [OPC_W-1:0] opcode;
   logic [2:0]       funct3;
   logic [6:0]       funct7;
   logic [N-1:0]     imm_i;
   logic [N-1:0]     imm_s;
   logic [N-1:0]     imm_b;
   logic [N-1:0]     imm_sh;
   bundle_t          dec_c;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign imm_i  = {{(N-12){in_instr[31]}}, in_instr[31:20]};
   assign imm_s  = {{(N-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b  = {{(N-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
   // Shift amounts are zero-extended because the ALU shifts by the whole operand
   assign imm_sh = {{(N-5){1'b0}}, in_instr[24:20]};

   // Defaults describe the illegal bundle; each legal encoding overrides them
   always_comb begin
      dec_c           = '0;
      dec_c.alu_op    = ALU_ADD;
      dec_c.rs1       = in_instr[19:15];
      dec_c.rs2       = in_instr[24:20];
      dec_c.rd        = in_instr[11:7];
      dec_c.illegal   = 1'b1;
      case (opcode)
         OPC_OP: begin
            if (funct7 == F7_BASE) begin
               dec_c.alu_op  = f3_op(funct3);
               dec_c.alusrc  = 1'b1;
               dec_c.rd_we   = 1'b1;
               dec_c.illegal = 1'b0;
            end else if ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
               dec_c.alu_op  = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
               dec_c.alusrc  = 1'b1;
               dec_c.rd_we   = 1'b1;
               dec_c.illegal = 1'b0;
            end
         end
         OPC_OP_IMM: begin
            if (funct3 == 3'b001) begin
               if (funct7 == F7_BASE) begin
                  dec_c.alu_op  = ALU_SLL;
                  dec_c.imm     = imm_sh;
                  dec_c.rd_we   = 1'b1;
                  dec_c.illegal = 1'b0;
               end
            end else if (funct3 == 3'b101) begin
               if ((funct7 == F7_BASE) || (funct7 == F7_ALT)) begin
                  dec_c.alu_op  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                  dec_c.imm     = imm_sh;
                  dec_c.rd_we   = 1'b1;
                  dec_c.illegal = 1'b0;
               end
            end else begin
               dec_c.alu_op  = f3_op(funct3);
               dec_c.imm     = imm_i;
               dec_c.rd_we   = 1'b1;
               dec_c.illegal = 1'b0;
            end
         end
         OPC_LOAD: begin
            dec_c.imm     = imm_i;
            dec_c.rd_we   = 1'b1;
            dec_c.illegal = 1'b0;
         end
         OPC_STORE: begin
            dec_c.imm     = imm_s;
            dec_c.illegal = 1'b0;
         end
         OPC_BRANCH: begin
            if ((funct3 != 3'b010) && (funct3 != 3'b011)) begin
               dec_c.alu_op    = (funct3[2] == 1'b0) ? ALU_EQ :
                                 (funct3[1] == 1'b0) ? ALU_SLT : ALU_SLTU;
               dec_c.alusrc    = 1'b1;
               dec_c.imm       = imm_b;
               dec_c.is_branch = 1'b1;
               dec_c.br_invert = funct3[0];
               dec_c.illegal   = 1'b0;
            end
         end
         default: ;
      endcase
   end

   state_t  state_q, state_d;
   bundle_t out_q, out_d;
   bundle_t skid_q, skid_d;
   logic    in_ready_q, in_ready_d;
   logic    out_valid_q, out_valid_d;
   logic    in_fire_c;
   logic    out_fire_c;

   assign in_fire_c  = in_valid & in_ready_q;
   assign out_fire_c = out_valid_q & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_EMPTY;
         out_q       <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Skid-buffer occupancy; the output register only changes when empty or draining
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      case (state_q)
         S_EMPTY: begin
            if (in_fire_c) begin
               out_d   = dec_c;
               state_d = S_ONE;
            end
         end
         S_ONE: begin
            if (in_fire_c && out_fire_c) begin
               out_d = dec_c;
            end else if (in_fire_c) begin
               skid_d  = dec_c;
               state_d = S_TWO;
            end else if (out_fire_c) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: begin
            if (out_fire_c) begin
               out_d   = skid_q;
               state_d = S_ONE;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      in_ready_d  = (state_d != S_TWO);
      out_valid_d = (state_d != S_EMPTY);
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = out_valid_q;
   assign out_alu_op    = out_q.alu_op;
   assign out_alusrc    = out_q.alusrc;
   assign out_imm       = out_q.imm;
   assign out_rs1       = out_q.rs1;
   assign out_rs2       = out_q.rs2;
   assign out_rd        = out_q.rd;
   assign out_rd_we     = out_q.rd_we;
   assign out_is_branch = out_q.is_branch;
   assign out_br_invert = out_q.br_invert;
   assign out_illegal   = out_q.illegal;

`ifdef ALU_DEC_PERF_CNT_EN
   logic [31:0] perf_decoded_q;
   logic [31:0] perf_illegal_q;

   // Free-running transfer counters, wrapping naturally at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_decoded_q <= '0;
         perf_illegal_q <= '0;
      end else if (out_fire_c) begin
         perf_decoded_q <= perf_decoded_q + 32'd1;
         if (out_q.illegal) begin
            perf_illegal_q <= perf_illegal_q + 32'd1;
         end
      end
   end

   assign perf_decoded = perf_decoded_q;
   assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Bench for alu_ctrl_decoder: directed decode vectors, backpressure and reset-in-TWO sequences,
// then randomized traffic scored against a behavioural decode model and an in-order queue.
`timescale 1ns/1ps
module tb_alu_ctrl_decoder;

   localparam int unsigned N       = 32;
   localparam int          NUM_RND = 400;

   typedef struct packed {
      logic [3:0]  alu_op;
      logic        alusrc;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rd_we;
      logic        is_branch;
      logic        br_invert;
      logic        illegal;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] instr;
      exp_t        exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_instr;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   out_alu_op;
   logic         out_alusrc;
   logic [N-1:0] out_imm;
   logic [4:0]   out_rs1;
   logic [4:0]   out_rs2;
   logic [4:0]   out_rd;
   logic         out_rd_we;
   logic         out_is_branch;
   logic         out_br_invert;
   logic         out_illegal;
`ifdef ALU_DEC_PERF_CNT_EN
   logic [31:0]  perf_decoded;
   logic [31:0]  perf_illegal;
   int           ref_dec;
   int           ref_ill;
`endif

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   alu_ctrl_decoder #(.N(N)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_alu_op    (out_alu_op),
      .out_alusrc    (out_alusrc),
      .out_imm       (out_imm),
      .out_rs1       (out_rs1),
      .out_rs2       (out_rs2),
      .out_rd        (out_rd),
      .out_rd_we     (out_rd_we),
      .out_is_branch (out_is_branch),
      .out_br_invert (out_br_invert),
      .out_illegal   (out_illegal)
`ifdef ALU_DEC_PERF_CNT_EN
      ,
      .perf_decoded  (perf_decoded),
      .perf_illegal  (perf_illegal)
`endif
   );

`ifdef ALU_DEC_PERF_CNT_EN
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_dec <= 0;
         ref_ill <= 0;
      end else if (out_valid && out_ready) begin
         ref_dec <= ref_dec + 1;
         if (out_illegal) ref_ill <= ref_ill + 1;
      end
   end
`endif

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [55:0] dut_bundle();
      return {out_alu_op, out_alusrc, 32'(out_imm), out_rs1, out_rs2, out_rd,
              out_rd_we, out_is_branch, out_br_invert, out_illegal};
   endfunction

   function automatic logic [3:0] alu_of_f3(input logic [2:0] f3);
      case (f3)
         3'd0: return 4'h0;
         3'd1: return 4'h9;
         3'd2: return 4'h6;
         3'd3: return 4'h8;
         3'd4: return 4'h4;
         3'd5: return 4'hA;
         3'd6: return 4'h3;
         default: return 4'h2;
      endcase
   endfunction

   function automatic int signed12(input logic [11:0] v);
      int r;
      r = int'(v);
      if (r >= 2048) r -= 4096;
      return r;
   endfunction

   // Reference decode from the ISA rules, immediates built with integer arithmetic
   function automatic exp_t model(input logic [31:0] w);
      exp_t       e;
      int         imm;
      bit         ok;
      logic [6:0] f7;
      logic [2:0] f3;
      f7 = w[31:25];
      f3 = w[14:12];
      ok = 1'b0;
      imm = 0;
      e = '0;
      e.rs1 = w[19:15];
      e.rs2 = w[24:20];
      e.rd  = w[11:7];
      case (w[6:0])
         7'h33: begin
            e.alusrc = 1'b1;
            e.rd_we  = 1'b1;
            if (f7 == 7'h00) begin ok = 1'b1; e.alu_op = alu_of_f3(f3); end
            else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; e.alu_op = 4'h1; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; e.alu_op = 4'hB; end
         end
         7'h13: begin
            e.rd_we  = 1'b1;
            e.alu_op = alu_of_f3(f3);
            if (f3 == 3'd1 || f3 == 3'd5) begin
               imm = int'(w[24:20]);
               ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
               if (f3 == 3'd5 && f7 == 7'h20) e.alu_op = 4'hB;
            end else begin
               ok = 1'b1;
               imm = signed12(w[31:20]);
            end
         end
         7'h03: begin ok = 1'b1; e.rd_we = 1'b1; imm = signed12(w[31:20]); end
         7'h23: begin ok = 1'b1; imm = signed12({w[31:25], w[11:7]}); end
         7'h63: begin
            ok = (f3 != 3'd2) && (f3 != 3'd3);
            e.alusrc    = 1'b1;
            e.is_branch = 1'b1;
            e.br_invert = f3[0];
            e.alu_op    = (f3[2] == 1'b0) ? 4'h5 : ((f3[1] == 1'b0) ? 4'h6 : 4'h8);
            imm = (int'(w[31]) << 12) + (int'(w[7]) << 11) + (int'(w[30:25]) << 5)
                + (int'(w[11:8]) << 1);
            if (imm >= 4096) imm -= 8192;
         end
         default: ;
      endcase
      e.imm = 32'(imm);
      if (!ok) begin
         e.alu_op = 4'h0; e.alusrc = 1'b0; e.imm = 32'h0; e.rd_we = 1'b0;
         e.is_branch = 1'b0; e.br_invert = 1'b0; e.illegal = 1'b1;
      end
      return e;
   endfunction

   function automatic vec_t mk(input string name, input logic [31:0] w, input logic [3:0] op,
                               input logic src, input logic [31:0] imm, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd, input logic we,
                               input logic br, input logic inv, input logic ill);
      vec_t v;
      v.name = name;
      v.instr = w;
      v.exp = {op, src, imm, rs1, rs2, rd, we, br, inv, ill};
      return v;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 7))
         0: begin w[6:0] = 7'h33; w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
         1: begin
            w[6:0] = 7'h13;
            if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
         end
         2: w[6:0] = 7'h03;
         3: w[6:0] = 7'h23;
         4, 5: w[6:0] = 7'h63;
         6: w[6:0] = 7'h33;
         default: ;
      endcase
      return w;
   endfunction

   vec_t        vecs[14];
   exp_t        q[$];
   logic [55:0] b0;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = mk("add",      32'h002081B3, 4'h0, 1, 32'h0,        1,  2,  3,  1, 0, 0, 0);
      vecs[1]  = mk("addi_m1",  32'hFFF00293, 4'h0, 0, 32'hFFFFFFFF, 0,  31, 5,  1, 0, 0, 0);
      vecs[2]  = mk("srai",     32'h40335313, 4'hB, 0, 32'h3,        6,  3,  6,  1, 0, 0, 0);
      vecs[3]  = mk("bne",      32'hFE209CE3, 4'h5, 1, 32'hFFFFFFF8, 1,  2,  25, 0, 1, 1, 0);
      vecs[4]  = mk("all_ones", 32'hFFFFFFFF, 4'h0, 0, 32'h0,        31, 31, 31, 0, 0, 0, 1);
      vecs[5]  = mk("sub",      32'h402081B3, 4'h1, 1, 32'h0,        1,  2,  3,  1, 0, 0, 0);
      vecs[6]  = mk("sw_p8",    32'h0020A423, 4'h0, 0, 32'h8,        1,  2,  8,  0, 0, 0, 0);
      vecs[7]  = mk("sw_m4",    32'hFE20AE23, 4'h0, 0, 32'hFFFFFFFC, 1,  2,  28, 0, 0, 0, 0);
      vecs[8]  = mk("bgeu",     32'h0020F863, 4'h8, 1, 32'h10,       1,  2,  16, 0, 1, 1, 0);
      vecs[9]  = mk("br_f3_2",  32'h0020A863, 4'h0, 0, 32'h0,        1,  2,  16, 0, 0, 0, 1);
      vecs[10] = mk("slli_bad", 32'h40109093, 4'h0, 0, 32'h0,        1,  1,  1,  0, 0, 0, 1);
      vecs[11] = mk("slli",     32'h00109093, 4'h9, 0, 32'h1,        1,  1,  1,  1, 0, 0, 0);
      vecs[12] = mk("lw",       32'h0040A203, 4'h0, 0, 32'h4,        1,  4,  4,  1, 0, 0, 0);
      vecs[13] = mk("mul",      32'h022081B3, 4'h0, 0, 32'h0,        1,  2,  3,  0, 0, 0, 1);

      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_bundle", dut_bundle(), 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", in_ready, 1);
      chk("rel_out_valid", out_valid, 0);

      // Directed table: one instruction per cycle with the consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         in_valid = 1'b1;
         in_instr = vecs[i].instr;
         @(negedge clk);
         in_valid = 1'b0;
         chk({vecs[i].name, "_valid"}, out_valid, 1);
         chk(vecs[i].name, dut_bundle(), vecs[i].exp);
      end
      @(negedge clk);
      chk("dir_drained", out_valid, 0);
`ifdef ALU_DEC_PERF_CNT_EN
      chk("perf_dec_dir", perf_decoded, 32'(ref_dec));
      chk("perf_ill_dir", perf_illegal, 32'(ref_ill));
      chk("perf_ill_count", perf_illegal, 4);
`endif

      // Backpressure: three offered, two accepted, then drain in order
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
      @(negedge clk) in_instr = 32'h00200113;
      @(negedge clk) in_instr = 32'h00300193;
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_head", dut_bundle(), model(32'h00100093));
      b0 = dut_bundle();
      @(negedge clk);
      chk("bp_in_ready_hold", in_ready, 0);
      chk("bp_hold", dut_bundle(), b0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_second", dut_bundle(), model(32'h00200113));
      chk("bp_in_ready_back", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_third", dut_bundle(), model(32'h00300193));
      chk("bp_third_valid", out_valid, 1);
      @(negedge clk);
      chk("bp_empty", out_valid, 0);

      // Reset while both entries are full
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00400213;
      @(negedge clk) in_instr = 32'h00500293;
      @(negedge clk) in_valid = 1'b0;
      chk("two_in_ready", in_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_bundle", dut_bundle(), 0);
      @(negedge clk) rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_rel_in_ready", in_ready, 1);
      begin
         int stale;
         stale = 0;
         for (int i = 0; i < 4; i++) begin
            if (out_valid) stale++;
            @(negedge clk);
         end
         chk("midrst_no_stale", 32'(stale), 0);
      end

      // Random traffic with random backpressure
      begin
         int          sent, recvd, cycles;
         logic        rdy_seen, prev_ov, prev_or;
         logic [55:0] prev_b;
         exp_t        e;
         sent = 0; recvd = 0; cycles = 0;
         rdy_seen = 1'b0; prev_ov = 1'b0; prev_or = 1'b0; prev_b = '0;
         while (recvd < NUM_RND && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (in_valid && rdy_seen) begin
               q.push_back(model(in_instr));
               sent++;
               in_valid = 1'b0;
            end
            chk("rnd_in_ready", in_ready, (q.size() < 2) ? 1 : 0);
            chk("rnd_out_valid", out_valid, (q.size() > 0) ? 1 : 0);
            if (prev_ov && !prev_or) chk("rnd_stable", dut_bundle(), prev_b);
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  chk("rnd_extra", 1, 0);
               end else begin
                  e = q.pop_front();
                  chk($sformatf("rnd_%0d", recvd), dut_bundle(), e);
                  recvd++;
               end
            end
            prev_ov = out_valid; prev_or = out_ready; prev_b = dut_bundle();
            if (!in_valid && sent < NUM_RND && $urandom_range(0, 3) != 0) begin
               in_valid = 1'b1;
               in_instr = gen_instr();
            end
            rdy_seen = in_ready;
         end
         chk("rnd_all_received", 32'(recvd), 32'(NUM_RND));
         chk("rnd_queue_empty", 32'(q.size()), 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("final_empty", out_valid, 0);
`ifdef ALU_DEC_PERF_CNT_EN
      chk("perf_dec_final", perf_decoded, 32'(ref_dec));
      chk("perf_ill_final", perf_illegal, 32'(ref_ill));
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
